if_fetch_ctrl: RTL and testbench

//  Fetch sequencer for the IF stage. Owns the fetch PC, issues requests to instruction memory

---
 rtl/if_pkg.sv | 19 +
 rtl/if_fetch_buf.sv | 58 +++++
 rtl/if_fetch_ctrl.sv | 117 +++++++++++
 tb/tb_if_fetch_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, word
// geometry and the NOP that ID substitutes while no instruction is valid.
package if_pkg;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    localparam int unsigned PC_STEP = 4;
    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    // Bits needed to count 0..max_val inclusive.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// Fetch buffer: small synchronous FIFO of returned instruction words with
// push, pop, flush and an occupancy count. The head word is read combinationally.
module if_fetch_buf
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic [INSTR_W-1:0] i_data,
    input  logic               i_pop,
    input  logic               i_flush,
    output logic [INSTR_W-1:0] o_head,
    output logic [CW-1:0]      o_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_rd_ptr;
    logic [AW-1:0]      r_wr_ptr;
    logic [CW-1:0]      r_count;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        (!i_flush && i_push && !i_pop) |-> (r_count < CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
        (!i_flush && i_pop) |-> (r_count != '0));

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, issues credit-limited imem
// requests, buffers in-order responses for ID and discards stale ones after redirects.
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter int unsigned      WIDTH           = 32,
    parameter logic [WIDTH-1:0] RESET_PC        = '0,
    parameter int unsigned      MAX_OUTSTANDING = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   PC_JMP,
    input  logic               branch,
    input  logic               ALU_zero,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [WIDTH-1:0]   imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               id_ready,
    output logic               id_valid,
    output logic [INSTR_W-1:0] instruction,
    output logic [WIDTH-1:0]   PC
);

    localparam int unsigned CW = cnt_w(MAX_OUTSTANDING);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [WIDTH-1:0]   r_fetch_pc;
    logic [WIDTH-1:0]   r_head_pc;
    logic [CW-1:0]      r_outstanding;
    logic [CW-1:0]      r_discard;
    logic [CW-1:0]      w_buf_count;
    logic [CW:0]        w_inflight;
    logic               w_credit_ok;
    logic               w_redirect;
    logic               w_req_fire;
    logic               w_rsp_drop;
    logic               w_push;
    logic               w_pop;
    logic [INSTR_W-1:0] w_head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= BOOT;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_redirect     = 1'b0;
        imem_req_valid = 1'b0;
        unique case (r_state)
            BOOT: w_state_nxt = RUN;
            RUN: begin
                w_redirect     = branch & ALU_zero;
                imem_req_valid = !(branch & ALU_zero) && w_credit_ok;
            end
        endcase
    end

    assign w_inflight  = {1'b0, r_outstanding} + {1'b0, w_buf_count};
    assign w_credit_ok = w_inflight < (CW + 1)'(MAX_OUTSTANDING);
    assign w_req_fire  = imem_req_valid & imem_req_ready;
    assign w_rsp_drop  = imem_rsp_valid & (w_redirect | (r_discard != '0));
    assign w_push      = imem_rsp_valid & ~w_rsp_drop;
    assign w_pop       = id_valid & id_ready & ~w_redirect;

    assign imem_req_addr = r_fetch_pc;
    assign id_valid      = (w_buf_count != '0);
    assign instruction   = id_valid ? w_head : '0;
    assign PC            = r_head_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_head_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
            if (w_redirect) begin
                r_fetch_pc <= PC_JMP;
                r_head_pc  <= PC_JMP;
                // r_discard always counts a subset of r_outstanding, so marking every
                // in-flight word stale is the accumulated total across back-to-back redirects.
                r_discard  <= r_outstanding - CW'(imem_rsp_valid);
            end else begin
                if (w_req_fire) r_fetch_pc <= r_fetch_pc + WIDTH'(PC_STEP);
                if (w_pop)      r_head_pc  <= r_head_pc + WIDTH'(PC_STEP);
                if (imem_rsp_valid && (r_discard != '0)) r_discard <= r_discard - 1'b1;
            end
        end
    end

    if_fetch_buf #(
        .DEPTH (MAX_OUTSTANDING),
        .CW    (CW)
    ) u_buf (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_data  (imem_rsp_data),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .o_head  (w_head),
        .o_count (w_buf_count)
    );

    a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (r_outstanding != '0));
    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        w_req_fire |-> (r_outstanding < CW'(MAX_OUTSTANDING)));
    a_discard_bound: assert property (@(posedge clk) disable iff (rst)
        r_discard <= r_outstanding);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: directed scenarios push expected fetch
// addresses and ID PCs; a negedge monitor pops and compares on every handshake.
module tb_if_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] PC_JMP;
    logic        branch;
    logic        ALU_zero;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] instruction;
    logic [31:0] PC;

    if_fetch_ctrl #(
        .WIDTH           (32),
        .RESET_PC        (32'h0),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .PC_JMP         (PC_JMP),
        .branch         (branch),
        .ALU_zero       (ALU_zero),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .instruction    (instruction),
        .PC             (PC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_pop    = 0;
    int          n_req    = 0;
    int          cyc      = 0;
    int          lat      = 1;
    logic [31:0] exp_id[$];
    logic [31:0] exp_req[$];
    pend_t       pend[$];

    function automatic logic [31:0] mk(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic consume(input int n);
        int target;
        int guard;
        target   = n_pop + n;
        guard    = 0;
        id_ready = 1'b1;
        while (n_pop < target && guard < 200) begin
            tick();
            guard++;
        end
        id_ready = 1'b0;
        check("consume_done", 32'(n_pop), 32'(target));
    endtask

    // Monitor: request and ID handshakes are decided by the values held over the negedge.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && imem_req_valid && imem_req_ready) begin
                n_req++;
                pend.push_back('{imem_req_addr, cyc + lat});
                if (exp_req.size() > 0) check("req_addr", imem_req_addr, exp_req.pop_front());
            end
            if (!rst && id_valid && id_ready && !(branch && ALU_zero)) begin
                n_pop++;
                if (exp_id.size() == 0) begin
                    n_checks++;
                    $display("FAIL id_extra: got PC %h, expected no instruction", PC);
                end else begin
                    e = exp_id.pop_front();
                    check("id_pc", PC, e);
                    check("id_instr", instruction, mk(e));
                end
            end
        end
    end

    // Instruction memory model: in-order responses, lat cycles after accept.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_DEAD;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                pend.delete();
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_DEAD;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mk(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_DEAD;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n0;
        int guard;
        rst            = 1'b1;
        id_ready       = 1'b0;
        imem_req_ready = 1'b1;
        branch         = 1'b0;
        ALU_zero       = 1'b0;
        PC_JMP         = '0;

        // 1: reset and boot
        @(posedge clk);
        #2;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_instr", instruction, 32'd0);
        check("rst_pc", PC, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'd0);
        #3 rst = 1'b0;
        exp_req.push_back(32'h0); exp_req.push_back(32'h4); exp_req.push_back(32'h8);
        exp_id.push_back(32'h0);  exp_id.push_back(32'h4);  exp_id.push_back(32'h8);
        #2;
        check("boot_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        check("run_req_valid", 32'(imem_req_valid), 32'd1);
        consume(3);

        // 2: backpressure
        n0 = n_req;
        repeat (10) tick();
        check("bp_req_valid", 32'(imem_req_valid), 32'd0);
        check("bp_id_valid", 32'(id_valid), 32'd1);
        check("bp_reqs_le2", 32'((n_req - n0) <= 2), 32'd1);
        exp_id.push_back(32'hC);  exp_id.push_back(32'h10);
        exp_id.push_back(32'h14); exp_id.push_back(32'h18);
        consume(4);

        // 3: taken redirect with 8 and 12 in flight
        rst = 1'b1;
        lat = 3;
        tick();
        rst = 1'b0;
        exp_id.push_back(32'h0); exp_id.push_back(32'h4);
        id_ready = 1'b1;
        guard = 0;
        while (!(pend.size() == 2 && pend[0].addr == 32'h8) && guard < 50) begin
            tick();
            guard++;
        end
        check("t3_inflight_8_12", 32'(pend.size() == 2 && pend[1].addr == 32'hC), 32'd1);
        exp_req.push_back(32'h100);
        branch = 1'b1; ALU_zero = 1'b1; PC_JMP = 32'h100; id_ready = 1'b0;
        tick();
        branch = 1'b0; ALU_zero = 1'b0;
        exp_id.push_back(32'h100); exp_id.push_back(32'h104);
        consume(2);

        // 4: branch not taken
        repeat (6) tick();
        branch = 1'b1; ALU_zero = 1'b0; PC_JMP = 32'h500;
        tick();
        branch = 1'b0;
        check("nt_id_valid", 32'(id_valid), 32'd1);
        check("nt_pc", PC, 32'h108);
        exp_id.push_back(32'h108); exp_id.push_back(32'h10C); exp_id.push_back(32'h110);
        consume(3);

        // 5: redirect coinciding with a response and a pop, then back-to-back
        lat = 1;
        repeat (8) tick();
        exp_id.push_back(32'h114);
        consume(1);
        guard = 0;
        while (!(imem_rsp_valid && id_valid) && guard < 20) begin
            tick();
            guard++;
        end
        check("t5_overlap_found", 32'(imem_rsp_valid && id_valid), 32'd1);
        exp_req.push_back(32'h300);
        branch = 1'b1; ALU_zero = 1'b1; PC_JMP = 32'h200; id_ready = 1'b1;
        tick();
        PC_JMP = 32'h300; id_ready = 1'b0;
        check("t5_flushed", 32'(id_valid), 32'd0);
        tick();
        branch = 1'b0; ALU_zero = 1'b0;
        check("t5_head_pc", PC, 32'h300);
        check("t5_still_empty", 32'(id_valid), 32'd0);
        exp_id.push_back(32'h300); exp_id.push_back(32'h304);
        consume(2);

        // 5: fetch PC wrap
        exp_req.push_back(32'hFFFF_FFF8); exp_req.push_back(32'hFFFF_FFFC);
        exp_req.push_back(32'h0);         exp_req.push_back(32'h4);
        exp_id.push_back(32'hFFFF_FFF8);  exp_id.push_back(32'hFFFF_FFFC);
        exp_id.push_back(32'h0);          exp_id.push_back(32'h4);
        branch = 1'b1; ALU_zero = 1'b1; PC_JMP = 32'hFFFF_FFF8;
        tick();
        branch = 1'b0; ALU_zero = 1'b0;
        consume(4);

        // 6: async reset with a full buffer
        repeat (10) tick();
        check("t6_full_id_valid", 32'(id_valid), 32'd1);
        check("t6_full_req_valid", 32'(imem_req_valid), 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("t6_async_id_valid", 32'(id_valid), 32'd0);
        check("t6_async_req_valid", 32'(imem_req_valid), 32'd0);
        check("t6_async_pc", PC, 32'd0);
        check("t6_async_instr", instruction, 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        exp_req.push_back(32'h0); exp_req.push_back(32'h4);
        exp_id.push_back(32'h0);  exp_id.push_back(32'h4);
        consume(2);

        repeat (3) tick();
        check("exp_id_drained", 32'(exp_id.size()), 32'd0);
        check("exp_req_drained", 32'(exp_req.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
